// File: rtl/instr_mem_param_if.sv
// Boot-load and fetch bus of the parametrised instruction memory.
// The memory side uses modport slave; the PC/loader/decoder side uses modport master.
interface instr_mem_param_if #(
    parameter int OPC_W = 3,
    parameter int OPR_W = 5,
    parameter int PC_W  = 5
);
    logic                   Ld_we;
    logic [PC_W-1:0]        Ld_addr;
    logic [OPC_W+OPR_W-1:0] Ld_data;
    logic                   Ld_done;
    logic                   Fetch_req;
    logic                   Stall;
    logic [PC_W-1:0]        PC;
    logic [OPC_W-1:0]       Opcode;
    logic [OPR_W-1:0]       Address;
    logic                   Valid;
    logic                   Running;
    logic                   Fault;
    logic                   Par_err;

    modport master (
        output Ld_we, Ld_addr, Ld_data, Ld_done, Fetch_req, Stall, PC,
        input  Opcode, Address, Valid, Running, Fault, Par_err
    );

    modport slave (
        input  Ld_we, Ld_addr, Ld_data, Ld_done, Fetch_req, Stall, PC,
        output Opcode, Address, Valid, Running, Fault, Par_err
    );
endinterface

// File: rtl/instr_mem_param.sv
// Loadable instruction RAM with a LOAD/RUN mode, a registered fetch port and sticky fault flags.
// Optional per-word even parity is enabled by defining INSTR_MEM_PARITY_EN.
module instr_mem_param #(
    parameter int OPC_W = 3,
    parameter int OPR_W = 5,
    parameter int PC_W  = 5,
    parameter int DEPTH = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    instr_mem_param_if.slave  bus
);
    localparam int W = OPC_W + OPR_W;
`ifdef INSTR_MEM_PARITY_EN
    localparam int MW = W + 1;
`else
    localparam int MW = W;
`endif

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

`ifdef INSTR_MEM_PARITY_EN
    function automatic logic even_par(input logic [W-1:0] d);
        return ^d;
    endfunction
`endif

    state_t               state_q, state_d;
    logic                 running_q, running_d;
    logic                 valid_q, valid_d;
    logic [OPC_W-1:0]     opc_q, opc_d;
    logic [OPR_W-1:0]     adr_q, adr_d;
    logic                 fault_q, fault_d;
    logic [DEPTH-1:0]     written_q, written_d;
    logic                 par_err_q, par_err_d;
    logic [MW-1:0]        mem_q [DEPTH];

    logic                 ld_in_range_s;
    logic                 pc_in_range_s;
    logic                 wr_en_s;
    logic                 rd_hit_s;
    logic [MW-1:0]        rd_word_s;

    // Range tests are widened by one bit so DEPTH == 2**PC_W does not wrap to zero.
    assign ld_in_range_s = ({1'b0, bus.Ld_addr} < (PC_W+1)'(DEPTH));
    assign pc_in_range_s = ({1'b0, bus.PC} < (PC_W+1)'(DEPTH));
    assign wr_en_s       = (state_q == LOAD) && bus.Ld_we && ld_in_range_s;

    // Read mux: unwritten or out-of-range words read back as zero.
    always_comb begin
        rd_hit_s  = 1'b0;
        rd_word_s = '0;
        if (pc_in_range_s) begin
            rd_hit_s = written_q[bus.PC];
        end else begin
            rd_hit_s = 1'b0;
        end
        if (rd_hit_s) begin
            rd_word_s = mem_q[bus.PC];
        end else begin
            rd_word_s = '0;
        end
    end

    // Next-state for mode, written bitmap, fetch outputs and sticky flags.
    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        valid_d   = valid_q;
        opc_d     = opc_q;
        adr_d     = adr_q;
        fault_d   = fault_q;
        written_d = written_q;
        par_err_d = par_err_q;

        case (state_q)
            LOAD: begin
                if (bus.Ld_done) begin
                    state_d = RUN;
                end else begin
                    state_d = LOAD;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = LOAD;
        endcase
        running_d = (state_d == RUN);

        if (wr_en_s) begin
            written_d[bus.Ld_addr] = 1'b1;
        end else begin
            written_d = written_q;
        end

        if (bus.Ld_we && ((state_q == RUN) || !ld_in_range_s)) begin
            fault_d = 1'b1;
        end else begin
            fault_d = fault_q;
        end

        // Stall freezes the outputs; otherwise a fetch request loads the word.
        if ((state_q == RUN) && !bus.Stall) begin
            if (bus.Fetch_req) begin
                valid_d        = 1'b1;
                {opc_d, adr_d} = rd_word_s[W-1:0];
                if (!pc_in_range_s) begin
                    fault_d = 1'b1;
                end else begin
                    fault_d = fault_d;
                end
`ifdef INSTR_MEM_PARITY_EN
                if (rd_hit_s && (rd_word_s[W] != even_par(rd_word_s[W-1:0]))) begin
                    par_err_d = 1'b1;
                end else begin
                    par_err_d = par_err_q;
                end
`endif
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Control and output registers; RAM contents are deliberately outside reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= LOAD;
            running_q <= 1'b0;
            valid_q   <= 1'b0;
            opc_q     <= '0;
            adr_q     <= '0;
            fault_q   <= 1'b0;
            written_q <= '0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            valid_q   <= valid_d;
            opc_q     <= opc_d;
            adr_q     <= adr_d;
            fault_q   <= fault_d;
            written_q <= written_d;
            par_err_q <= par_err_d;
        end
    end

    // Boot-load write port.
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
`ifdef INSTR_MEM_PARITY_EN
            mem_q[bus.Ld_addr] <= {even_par(bus.Ld_data), bus.Ld_data};
`else
            mem_q[bus.Ld_addr] <= bus.Ld_data;
`endif
        end
    end

    assign bus.Opcode  = opc_q;
    assign bus.Address = adr_q;
    assign bus.Valid   = valid_q;
    assign bus.Running = running_q;
    assign bus.Fault   = fault_q;
`ifdef INSTR_MEM_PARITY_EN
    assign bus.Par_err = par_err_q;
`else
    assign bus.Par_err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_mem_param.sv
// Directed bench for instr_mem_param: a stimulus process queues expected fetch results,
// a monitor pops and compares them on every cycle the DUT shows Valid.
module tb_instr_mem_param;
    localparam int OPC_W = 3;
    localparam int OPR_W = 5;
    localparam int PC_W  = 5;
    localparam int DEPTH = 24;

    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic [OPR_W-1:0] adr;
        logic             fault;
        logic             par;
    } exp_t;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;
    exp_t exp_q [$];

    instr_mem_param_if #(.OPC_W(OPC_W), .OPR_W(OPR_W), .PC_W(PC_W)) bus ();

    instr_mem_param #(.OPC_W(OPC_W), .OPR_W(OPR_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic we, input logic [PC_W-1:0] la, input logic [7:0] ld,
                        input logic done, input logic freq, input logic stall,
                        input logic [PC_W-1:0] pc);
        @(negedge Clk);
        bus.Ld_we     = we;
        bus.Ld_addr   = la;
        bus.Ld_data   = ld;
        bus.Ld_done   = done;
        bus.Fetch_req = freq;
        bus.Stall     = stall;
        bus.PC        = pc;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic fetch(input logic [PC_W-1:0] pc, input logic [7:0] word,
                         input logic fault, input logic par);
        step(1'b0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0, pc);
        exp_q.push_back({word, fault, par});
    endtask

    task automatic after_edge();
        @(posedge Clk);
        #2;
    endtask

    // Monitor: every Valid cycle must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (bus.Valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("opcode",  32'(bus.Opcode),  32'(e.opc));
                    check("address", 32'(bus.Address), 32'(e.adr));
                    check("fault",   32'(bus.Fault),   32'(e.fault));
                    check("par_err", 32'(bus.Par_err), 32'(e.par));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        bus.Ld_we = 1'b0; bus.Ld_addr = '0; bus.Ld_data = '0; bus.Ld_done = 1'b0;
        bus.Fetch_req = 1'b0; bus.Stall = 1'b0; bus.PC = '0;
        #1;
        check("rst_valid",   32'(bus.Valid),   32'd0);
        check("rst_running", 32'(bus.Running), 32'd0);
        check("rst_fault",   32'(bus.Fault),   32'd0);
        check("rst_opcode",  32'(bus.Opcode),  32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // First load session: includes an out-of-range write and a fetch while loading.
        step(1'b1, 5'd1, 8'hE5, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 5'd26, 8'h55, 1'b0, 1'b0, 1'b0, 5'd0);
        after_edge();
        check("load_oor_fault", 32'(bus.Fault), 32'd1);
        step(1'b0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd1);
        after_edge();
        check("load_fetch_ignored", 32'(bus.Valid), 32'd0);
        check("load_not_running",   32'(bus.Running), 32'd0);
        step(1'b1, 5'd3, 8'hBA, 1'b1, 1'b0, 1'b0, 5'd0);
        after_edge();
        check("run_after_done", 32'(bus.Running), 32'd1);
        fetch(5'd1, 8'hE5, 1'b1, 1'b0);
        after_edge();
        check("pre_reset_opcode", 32'(bus.Opcode), 32'd7);

        // Asynchronous reset while Valid is high.
        #1;
        Reset = 1'b1;
        #1;
        check("async_opcode",  32'(bus.Opcode),  32'd0);
        check("async_address", 32'(bus.Address), 32'd0);
        check("async_valid",   32'(bus.Valid),   32'd0);
        check("async_running", 32'(bus.Running), 32'd0);
        check("async_fault",   32'(bus.Fault),   32'd0);
        check("async_par",     32'(bus.Par_err), 32'd0);
        idle();
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Second load session; Ld_done coincides with the last write.
        step(1'b1, 5'd3, 8'hBA, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 5'd5, 8'h47, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 5'd2, 8'h3C, 1'b1, 1'b0, 1'b0, 5'd0);
        after_edge();
        check("run2_running", 32'(bus.Running), 32'd1);
        fetch(5'd3, 8'hBA, 1'b0, 1'b0);
        fetch(5'd1, 8'h00, 1'b0, 1'b0);
        fetch(5'd7, 8'h00, 1'b0, 1'b0);
        step(1'b1, 5'd7, 8'hFF, 1'b1, 1'b0, 1'b0, 5'd0);
        after_edge();
        check("run_write_fault", 32'(bus.Fault),   32'd1);
        check("run_stays",       32'(bus.Running), 32'd1);
        fetch(5'd7, 8'h00, 1'b1, 1'b0);
        fetch(5'd30, 8'h00, 1'b1, 1'b0);
        fetch(5'd3, 8'hBA, 1'b1, 1'b0);
        fetch(5'd5, 8'h47, 1'b1, 1'b0);
        fetch(5'd2, 8'h3C, 1'b1, 1'b0);
        fetch(5'd3, 8'hBA, 1'b1, 1'b0);
        fetch(5'd5, 8'h47, 1'b1, 1'b0);

        // Stall holds the previous word even with a live fetch request.
        fetch(5'd3, 8'hBA, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd5);
            exp_q.push_back({8'hBA, 1'b1, 1'b0});
        end
        fetch(5'd5, 8'h47, 1'b1, 1'b0);
        idle();
        after_edge();
        check("idle_valid_low", 32'(bus.Valid),   32'd0);
        check("idle_opc_hold",  32'(bus.Opcode),  32'd2);
        check("idle_adr_hold",  32'(bus.Address), 32'd7);

`ifdef INSTR_MEM_PARITY_EN
        @(negedge Clk);
        dut.mem_q[2][0] = ~dut.mem_q[2][0];
        fetch(5'd2, 8'h3D, 1'b1, 1'b1);
        after_edge();
        check("par_err_set", 32'(bus.Par_err), 32'd1);
`else
        fetch(5'd2, 8'h3C, 1'b1, 1'b0);
        after_edge();
        check("par_err_zero", 32'(bus.Par_err), 32'd0);
`endif
        idle();
        after_edge();
        after_edge();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
